// File: rtl/beep_note_player_if.sv
// beep_note_player_if
//   Groups the key-input and buzzer/status signals of beep_note_player.
//   master: the side that drives scan codes and mode/octave (PS/2 decoder, bench)
//   slave : the note player itself
//
//   KEY_CODE  [7:0]  PS/2 scan code
//   KEY_VALID        one-cycle strobe qualifying KEY_CODE
//   MODE             0 = live, 1 = queued
//   OCTAVE    [1:0]  right-shift applied to the note divider
//   BEEP             buzzer drive
//   BUSY             queued playback in progress or notes waiting
//   FIFO_CNT         number of queued notes
//   FIFO_FULL        FIFO_CNT == FIFO_DEPTH
//   DROP             one-cycle pulse when a note is lost to a full queue
interface beep_note_player_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    KEY_CODE;
    logic          KEY_VALID;
    logic          MODE;
    logic [1:0]    OCTAVE;
    logic          BEEP;
    logic          BUSY;
    logic [CW-1:0] FIFO_CNT;
    logic          FIFO_FULL;
    logic          DROP;

    modport master (
        output KEY_CODE, KEY_VALID, MODE, OCTAVE,
        input  BEEP, BUSY, FIFO_CNT, FIFO_FULL, DROP
    );

    modport slave (
        input  KEY_CODE, KEY_VALID, MODE, OCTAVE,
        output BEEP, BUSY, FIFO_CNT, FIFO_FULL, DROP
    );
endinterface

// File: rtl/beep_note_player.sv
// beep_note_player
//   Turns PS/2 scan codes into a square-wave buzzer tone. In live mode the
//   last valid key plays until replaced; in queued mode keys are buffered in
//   a FIFO and each plays for NOTE_MS followed by GAP_MS of silence.
//
//   CLK_50M  system clock
//   RST_N    asynchronous active-low reset
//   bus      beep_note_player_if.slave (key input, mode/octave, BEEP and status)
module beep_note_player #(
    parameter int CLK_HZ     = 50000000,
    parameter int FIFO_DEPTH = 8,
    parameter int NOTE_MS    = 200,
    parameter int GAP_MS     = 20,
    parameter int CNT_W      = 16
) (
    input  logic                CLK_50M,
    input  logic                RST_N,
    beep_note_player_if.slave   bus
);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int TICK   = CLK_HZ / 1000;
    localparam int PRE_W  = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int MS_MAX = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK - 1);
    localparam logic [MS_W-1:0]  NOTE_LAST = MS_W'(NOTE_MS - 1);
    localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t             state;
    logic               mode_q;
    logic [CNT_W-1:0]   div;
    logic [CNT_W-1:0]   tone_cnt;
    logic               beep;
    logic [PRE_W-1:0]   pre_cnt;
    logic [MS_W-1:0]    ms_cnt;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_cnt;
    logic               fifo_full;
    logic               drop;
    logic [CNT_W-1:0]   mem [FIFO_DEPTH];

    logic               code_valid;
    logic [CNT_W-1:0]   code_div;
    logic [CNT_W-1:0]   eff;
    logic               mode_chg;
    logic               tone_en;
    logic               tick;
    logic               push_req;
    logic               pop;
    logic               push_ok;

    // Scan code to half-period divider; code 70 is a rest (divider 0).
    always_comb begin
        code_valid = 1'b1;
        code_div   = '0;
        case (bus.KEY_CODE)
            8'h70:   code_div = '0;
            8'h69:   code_div = CNT_W'(47774);
            8'h72:   code_div = CNT_W'(42568);
            8'h7A:   code_div = CNT_W'(37919);
            8'h6B:   code_div = CNT_W'(35791);
            8'h73:   code_div = CNT_W'(31888);
            8'h74:   code_div = CNT_W'(28409);
            8'h6C:   code_div = CNT_W'(25309);
            8'h75:   code_div = CNT_W'(23889);
            8'h7D:   code_div = CNT_W'(21276);
            default: code_valid = 1'b0;
        endcase
    end

    // A key arriving in the same cycle as a mode change is discarded.
    // A push into a full FIFO still succeeds when the head leaves that cycle.
    assign eff      = div >> bus.OCTAVE;
    assign mode_chg = bus.MODE != mode_q;
    assign tone_en  = !bus.MODE || (state == PLAY);
    assign tick     = pre_cnt == PRE_LAST;
    assign push_req = bus.MODE && !mode_chg && bus.KEY_VALID && code_valid;
    assign pop      = bus.MODE && !mode_chg && (state == IDLE) && (fifo_cnt != '0);
    assign push_ok  = push_req && (!fifo_full || pop);

    always_ff @(posedge CLK_50M) begin
        if (push_ok) begin
            mem[wr_ptr] <= code_div;
        end
    end

    // Tone generator, ms prescaler, FIFO bookkeeping and the queued-mode
    // sequencer. Later assignments override the free-running tone update
    // whenever a note is loaded or playback stops.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            mode_q    <= 1'b0;
            state     <= IDLE;
            div       <= '0;
            tone_cnt  <= '0;
            beep      <= 1'b0;
            pre_cnt   <= '0;
            ms_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            fifo_full <= 1'b0;
            drop      <= 1'b0;
        end else begin
            mode_q  <= bus.MODE;
            drop    <= push_req && !push_ok;
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;

            // >= rather than == so a mid-tone octave raise cannot overrun.
            if (!tone_en || eff == '0) begin
                tone_cnt <= '0;
                beep     <= 1'b0;
            end else if (tone_cnt >= eff) begin
                tone_cnt <= '0;
                beep     <= ~beep;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end

            if (mode_chg || !bus.MODE) begin
                state     <= IDLE;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                fifo_cnt  <= '0;
                fifo_full <= 1'b0;
                if (mode_chg) begin
                    div      <= '0;
                    tone_cnt <= '0;
                    beep     <= 1'b0;
                end else if (bus.KEY_VALID && code_valid) begin
                    div      <= code_div;
                    tone_cnt <= '0;
                    beep     <= 1'b0;
                end
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_ok && !pop) begin
                    fifo_cnt  <= fifo_cnt + 1'b1;
                    fifo_full <= fifo_cnt == DEPTH_C - 1'b1;
                end else if (pop && !push_ok) begin
                    fifo_cnt  <= fifo_cnt - 1'b1;
                    fifo_full <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (pop) begin
                            div      <= mem[rd_ptr];
                            tone_cnt <= '0;
                            beep     <= 1'b0;
                            pre_cnt  <= '0;
                            ms_cnt   <= '0;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick) begin
                            if (ms_cnt == NOTE_LAST) begin
                                ms_cnt   <= '0;
                                tone_cnt <= '0;
                                beep     <= 1'b0;
                                state    <= (GAP_MS == 0) ? IDLE : GAP;
                            end else begin
                                ms_cnt <= ms_cnt + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (ms_cnt == GAP_LAST) begin
                                ms_cnt <= '0;
                                state  <= IDLE;
                            end else begin
                                ms_cnt <= ms_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.BEEP      = beep;
    assign bus.BUSY      = (state != IDLE) || (fifo_cnt != '0);
    assign bus.FIFO_CNT  = fifo_cnt;
    assign bus.FIFO_FULL = fifo_full;
    assign bus.DROP      = drop;
endmodule

// File: tb/tb_beep_note_player.sv
// tb_beep_note_player
//   Directed bench for beep_note_player with a 100 kHz tick base so one ms is
//   100 cycles: notes play 200 cycles, gaps last 100 cycles. Inputs are driven
//   and outputs sampled on the falling clock edge.
module tb_beep_note_player;
    localparam int CLK_HZ     = 100000;
    localparam int FIFO_DEPTH = 8;
    localparam int NOTE_MS    = 2;
    localparam int GAP_MS     = 1;
    localparam int CNT_W      = 16;

    logic CLK_50M = 1'b0;
    logic RST_N   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    beep_note_player_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    beep_note_player #(
        .CLK_HZ(CLK_HZ), .FIFO_DEPTH(FIFO_DEPTH), .NOTE_MS(NOTE_MS),
        .GAP_MS(GAP_MS), .CNT_W(CNT_W)
    ) dut (
        .CLK_50M(CLK_50M),
        .RST_N(RST_N),
        .bus(bus.slave)
    );

    always #10 CLK_50M = ~CLK_50M;

    // One-cycle KEY_VALID strobe, sampled by exactly one rising edge.
    task automatic push_key(input logic [7:0] code);
        bus.KEY_CODE  = code;
        bus.KEY_VALID = 1'b1;
        @(negedge CLK_50M);
        bus.KEY_VALID = 1'b0;
    endtask

    // Counts falling edges until BEEP reaches lvl, giving up at limit.
    task automatic wait_beep(input logic lvl, input int limit, output int n);
        n = 0;
        while (bus.BEEP !== lvl && n < limit) begin
            @(negedge CLK_50M);
            n++;
        end
    endtask

    task automatic test_reset();
        RST_N         = 1'b0;
        bus.KEY_CODE  = 8'h00;
        bus.KEY_VALID = 1'b0;
        bus.MODE      = 1'b0;
        bus.OCTAVE    = 2'd0;
        repeat (3) @(negedge CLK_50M);
        checks++; if (bus.BEEP !== 1'b0) begin failures++; $display("[TB] FAIL reset_beep got=%b exp=0", bus.BEEP); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.BUSY); end
        checks++; if (bus.FIFO_CNT !== 4'd0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", bus.FIFO_CNT); end
        checks++; if (bus.FIFO_FULL !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", bus.FIFO_FULL); end
        checks++; if (bus.DROP !== 1'b0) begin failures++; $display("[TB] FAIL reset_drop got=%b exp=0", bus.DROP); end
        RST_N = 1'b1;
        @(negedge CLK_50M);
    endtask

    task automatic test_live_tone();
        int n;
        bit silent;
        bus.MODE   = 1'b0;
        bus.OCTAVE = 2'd0;
        push_key(8'h69);
        wait_beep(1'b1, 50000, n);
        checks++; if (n !== 47775) begin failures++; $display("[TB] FAIL live_first_rise got=%0d exp=47775", n); end
        push_key(8'h70);
        checks++; if (bus.BEEP !== 1'b0) begin failures++; $display("[TB] FAIL live_rest_stop got=%b exp=0", bus.BEEP); end
        silent = 1'b1;
        repeat (20) begin
            @(negedge CLK_50M);
            if (bus.BEEP !== 1'b0) silent = 1'b0;
        end
        checks++; if (silent !== 1'b1) begin failures++; $display("[TB] FAIL live_rest_hold got=%b exp=1", silent); end
    endtask

    task automatic test_live_octave();
        int n;
        bus.OCTAVE = 2'd1;
        push_key(8'h7D);
        wait_beep(1'b1, 20000, n);
        checks++; if (n !== 10639) begin failures++; $display("[TB] FAIL oct1_first_rise got=%0d exp=10639", n); end
        bus.OCTAVE = 2'd3;
        wait_beep(1'b0, 5000, n);
        checks++; if (n !== 2660) begin failures++; $display("[TB] FAIL oct3_half_low got=%0d exp=2660", n); end
        wait_beep(1'b1, 5000, n);
        checks++; if (n !== 2660) begin failures++; $display("[TB] FAIL oct3_half_high got=%0d exp=2660", n); end
        push_key(8'h1C);
        wait_beep(1'b0, 5000, n);
        checks++; if (n !== 2659) begin failures++; $display("[TB] FAIL live_invalid_code got=%0d exp=2659", n); end
    endtask

    task automatic test_async_reset();
        int n;
        wait_beep(1'b1, 5000, n);
        checks++; if (n !== 2660) begin failures++; $display("[TB] FAIL pre_reset_half got=%0d exp=2660", n); end
        #2 RST_N = 1'b0;
        #1;
        checks++; if (bus.BEEP !== 1'b0) begin failures++; $display("[TB] FAIL areset_beep got=%b exp=0", bus.BEEP); end
        checks++; if (bus.BUSY !== 1'b0 || bus.FIFO_CNT !== 4'd0 || bus.DROP !== 1'b0)
            begin failures++; $display("[TB] FAIL areset_status got busy=%b cnt=%0d drop=%b exp=0,0,0", bus.BUSY, bus.FIFO_CNT, bus.DROP); end
        @(negedge CLK_50M);
        RST_N = 1'b1;
        @(negedge CLK_50M);
    endtask

    task automatic test_queued_sequence();
        int n;
        bus.MODE = 1'b1;
        repeat (2) @(negedge CLK_50M);
        push_key(8'h1C);
        checks++; if (bus.FIFO_CNT !== 4'd0 || bus.BUSY !== 1'b0 || bus.DROP !== 1'b0)
            begin failures++; $display("[TB] FAIL q_invalid_code got cnt=%0d busy=%b drop=%b exp=0,0,0", bus.FIFO_CNT, bus.BUSY, bus.DROP); end
        push_key(8'h69);
        push_key(8'h72);
        checks++; if (bus.FIFO_CNT !== 4'd1) begin failures++; $display("[TB] FAIL q_cnt_after_push got=%0d exp=1", bus.FIFO_CNT); end
        checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("[TB] FAIL q_busy_first got=%b exp=1", bus.BUSY); end
        n = 0;
        while (bus.FIFO_CNT !== 4'd0 && n < 1000) begin @(negedge CLK_50M); n++; end
        checks++; if (n !== 301) begin failures++; $display("[TB] FAIL q_second_pop got=%0d exp=301", n); end
        n = 0;
        while (bus.BUSY !== 1'b0 && n < 1000) begin @(negedge CLK_50M); n++; end
        checks++; if (n !== 300) begin failures++; $display("[TB] FAIL q_busy_fall got=%0d exp=300", n); end
    endtask

    task automatic test_queued_rest();
        int n;
        bit silent;
        push_key(8'h70);
        silent = 1'b1;
        n = 0;
        while (bus.BUSY !== 1'b0 && n < 1000) begin
            @(negedge CLK_50M);
            n++;
            if (bus.BEEP !== 1'b0) silent = 1'b0;
        end
        checks++; if (n !== 301) begin failures++; $display("[TB] FAIL q_rest_length got=%0d exp=301", n); end
        checks++; if (silent !== 1'b1) begin failures++; $display("[TB] FAIL q_rest_silent got=%b exp=1", silent); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] codes [9];
        codes = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
        push_key(8'h69);
        @(negedge CLK_50M);
        checks++; if (bus.FIFO_CNT !== 4'd0 || bus.BUSY !== 1'b1)
            begin failures++; $display("[TB] FAIL full_first_pop got cnt=%0d busy=%b exp=0,1", bus.FIFO_CNT, bus.BUSY); end
        for (int i = 0; i < 9; i++) begin
            push_key(codes[i]);
            if (i == 7) begin
                checks++; if (bus.FIFO_CNT !== 4'd8 || bus.FIFO_FULL !== 1'b1 || bus.DROP !== 1'b0)
                    begin failures++; $display("[TB] FAIL full_eighth got cnt=%0d full=%b drop=%b exp=8,1,0", bus.FIFO_CNT, bus.FIFO_FULL, bus.DROP); end
            end
        end
        checks++; if (bus.DROP !== 1'b1 || bus.FIFO_CNT !== 4'd8)
            begin failures++; $display("[TB] FAIL full_drop got drop=%b cnt=%0d exp=1,8", bus.DROP, bus.FIFO_CNT); end
        @(negedge CLK_50M);
        checks++; if (bus.DROP !== 1'b0) begin failures++; $display("[TB] FAIL full_drop_pulse got=%b exp=0", bus.DROP); end
        repeat (290) @(negedge CLK_50M);
        checks++; if (bus.FIFO_CNT !== 4'd8 || bus.BUSY !== 1'b1)
            begin failures++; $display("[TB] FAIL full_before_pop got cnt=%0d busy=%b exp=8,1", bus.FIFO_CNT, bus.BUSY); end
        push_key(8'h7A);
        checks++; if (bus.FIFO_CNT !== 4'd8 || bus.FIFO_FULL !== 1'b1 || bus.DROP !== 1'b0)
            begin failures++; $display("[TB] FAIL full_push_pop got cnt=%0d full=%b drop=%b exp=8,1,0", bus.FIFO_CNT, bus.FIFO_FULL, bus.DROP); end
    endtask

    task automatic test_mode_change();
        bit silent;
        bus.OCTAVE    = 2'd3;
        bus.MODE      = 1'b0;
        bus.KEY_CODE  = 8'h7D;
        bus.KEY_VALID = 1'b1;
        @(negedge CLK_50M);
        bus.KEY_VALID = 1'b0;
        checks++; if (bus.FIFO_CNT !== 4'd0 || bus.FIFO_FULL !== 1'b0)
            begin failures++; $display("[TB] FAIL mode_flush got cnt=%0d full=%b exp=0,0", bus.FIFO_CNT, bus.FIFO_FULL); end
        checks++; if (bus.BUSY !== 1'b0 || bus.BEEP !== 1'b0)
            begin failures++; $display("[TB] FAIL mode_idle got busy=%b beep=%b exp=0,0", bus.BUSY, bus.BEEP); end
        silent = 1'b1;
        repeat (2700) begin
            @(negedge CLK_50M);
            if (bus.BEEP !== 1'b0) silent = 1'b0;
        end
        checks++; if (silent !== 1'b1) begin failures++; $display("[TB] FAIL mode_key_ignored got=%b exp=1", silent); end
    endtask

    initial begin
        $display("[TB] beep_note_player directed test start");
        test_reset();
        test_live_tone();
        test_live_octave();
        test_async_reset();
        test_queued_sequence();
        test_queued_rest();
        test_fifo_full();
        test_mode_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
